// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial add/subtract units.
// Both units use the same state encoding so one sequencer can drive either.
package serial_arith_pkg;

    localparam int SERIAL_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_fs_bit.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
module serial_fs_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// en starts an operation from IDLE and acknowledges the result in DONE.
module sub_serial
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CNT_W-1:0] count;
    logic             brw;
    logic             fs_d;
    logic             fs_bout;
    logic             last_bit;

    serial_fs_bit u_fs (
        .x    (a_reg[0]),
        .y    (b_reg[0]),
        .bin  (brw),
        .d    (fs_d),
        .bout (fs_bout)
    );

    assign last_bit = (count == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Unused encodings fall through to IDLE so a corrupted state self-recovers.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: next_state = en ? SUB : IDLE;
            SUB:  next_state = last_bit ? DONE : SUB;
            DONE: next_state = en ? IDLE : DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            out    <= '0;
            count  <= '0;
            brw    <= 1'b0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        out    <= '0;
                        count  <= '0;
                        brw    <= 1'b0;
                        borrow <= 1'b0;
                        ovf    <= 1'b0;
                    end
                end
                SUB: begin
                    out   <= {fs_d, out[WIDTH-1:1]};
                    a_reg <= {1'b0, a_reg[WIDTH-1:1]};
                    b_reg <= {1'b0, b_reg[WIDTH-1:1]};
                    brw   <= fs_bout;
                    count <= count + 1'b1;
                    // Overflow: borrow into the MSB differs from borrow out of it.
                    if (last_bit) begin
                        borrow <= fs_bout;
                        ovf    <= brw ^ fs_bout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == SUB);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sub_serial.sv
// Directed testbench for sub_serial with hand-computed expected results.
module tb_sub_serial;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       borrow;
    logic       ovf;
    logic       busy;
    logic       done;

    int vectors;
    int miscompares;

    sub_serial #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .a      (a),
        .b      (b),
        .out    (out),
        .borrow (borrow),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start an operation and wait (bounded) for DONE; optionally disturb inputs during SUB.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input bit scramble);
        int n;
        @(negedge clk);
        a  = av;
        b  = bv;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        n  = 0;
        while (busy && n < 20) begin
            if (scramble) begin
                a  = 8'($urandom);
                b  = 8'($urandom);
                en = 1'($urandom_range(0, 1));
            end
            n++;
            @(negedge clk);
        end
        en = 1'b0;
        checkOutput("busy_cycles", n, 8);
    endtask

    task automatic expectResult(input string tag, input logic [7:0] eo, input logic eb, input logic ev);
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_out"}, out, eo);
        checkOutput({tag, "_borrow"}, borrow, eb);
        checkOutput({tag, "_ovf"}, ovf, ev);
    endtask

    task automatic acknowledge(input logic [7:0] eo);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        checkOutput("ack_done", done, 0);
        checkOutput("ack_busy", busy, 0);
        checkOutput("ack_out", out, eo);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        en  = 1'b0;
        a   = 8'h00;
        b   = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("rst_out", out, 0);
        checkOutput("rst_borrow", borrow, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        rst = 1'b0;

        applyStimulus(8'h05, 8'h03, 1'b0);
        expectResult("5m3", 8'h02, 1'b0, 1'b0);
        acknowledge(8'h02);

        applyStimulus(8'h03, 8'h05, 1'b0);
        expectResult("3m5", 8'hFE, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_out", out, 8'hFE);
            checkOutput("hold_borrow", borrow, 1);
            checkOutput("hold_done", done, 1);
        end
        acknowledge(8'hFE);
        @(negedge clk);
        checkOutput("idle_stays", busy, 0);

        applyStimulus(8'h80, 8'h01, 1'b0);
        expectResult("80m01", 8'h7F, 1'b0, 1'b1);
        acknowledge(8'h7F);

        applyStimulus(8'h7F, 8'hFF, 1'b0);
        expectResult("7Fm FF", 8'h80, 1'b1, 1'b1);
        acknowledge(8'h80);

        applyStimulus(8'hA5, 8'hA5, 1'b0);
        expectResult("A5mA5", 8'h00, 1'b0, 1'b0);
        acknowledge(8'h00);

        applyStimulus(8'h00, 8'h00, 1'b0);
        expectResult("00m00", 8'h00, 1'b0, 1'b0);
        acknowledge(8'h00);

        applyStimulus(8'h3C, 8'h11, 1'b1);
        expectResult("scramble", 8'h2B, 1'b0, 1'b0);
        acknowledge(8'h2B);

        // Reset in the middle of SUB must clear everything without waiting for a clock edge.
        @(negedge clk);
        a  = 8'h55;
        b  = 8'h22;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_out", out, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_borrow", borrow, 0);
        checkOutput("mid_rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(8'h10, 8'h20, 1'b0);
        expectResult("10m20", 8'hF0, 1'b1, 1'b0);
        acknowledge(8'hF0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
